// File: rtl/shiftreg_univ.sv
// Universal shift register with a small IDLE/RUN/DONE sequencer.
// An accepted start latches mode and count; LOAD, CLEAR, reserved and
// zero-count requests complete immediately, while shifts and rotates take
// one step per clock for the latched count and may be aborted mid-run.
//
// Ports:
//   clk        - clock, rising edge active
//   reset_n    - asynchronous active-low reset
//   start      - operation request, sampled only in IDLE
//   mode       - operation select (LOAD/SHL/SHR/ROL/ROR/ASR/CLEAR/reserved)
//   count      - number of shift steps
//   load_data  - parallel load value
//   serial_in  - fill bit for logical shifts, sampled every step
//   abort      - terminates a running operation
//   register   - current register contents
//   serial_out - bit shifted out by the most recent step
//   busy       - high while stepping
//   done       - one-cycle completion pulse
module shiftreg_univ #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] load_data,
    input  logic             serial_in,
    input  logic             abort,
    output logic [WIDTH-1:0] register,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_LOAD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ROL   = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ASR   = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_RSVD  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic             so_q, so_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_reg;
    logic             step_so;
    logic             immediate;

    // One step of the latched operation applied to the current contents.
    always_comb begin
        step_reg = reg_q;
        step_so  = so_q;
        case (mode_q)
            MODE_SHL: begin
                step_reg = {reg_q[WIDTH-2:0], serial_in};
                step_so  = reg_q[WIDTH-1];
            end
            MODE_SHR: begin
                step_reg = {serial_in, reg_q[WIDTH-1:1]};
                step_so  = reg_q[0];
            end
            MODE_ROL: begin
                step_reg = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                step_so  = reg_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_reg = {reg_q[0], reg_q[WIDTH-1:1]};
                step_so  = reg_q[0];
            end
            MODE_ASR: begin
                step_reg = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
                step_so  = reg_q[0];
            end
            default: begin
                step_reg = reg_q;
                step_so  = so_q;
            end
        endcase
    end

    // Requests that finish on the accept edge without entering RUN.
    assign immediate = (mode == MODE_LOAD) || (mode == MODE_CLEAR) ||
                       (mode == MODE_RSVD) || (count == CNT_W'(0));

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        reg_d   = reg_q;
        so_d    = so_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    cnt_d  = count;
                    if (immediate) begin
                        state_d = DONE;
                        if (mode == MODE_LOAD) begin
                            reg_d = load_data;
                        end else if (mode == MODE_CLEAR) begin
                            reg_d = {WIDTH{1'b0}};
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Abort wins over the step scheduled for this edge.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    reg_d = step_reg;
                    so_d  = step_so;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= 3'b000;
            cnt_q   <= CNT_W'(0);
            reg_q   <= {WIDTH{1'b0}};
            so_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign register   = reg_q;
    assign serial_out = so_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shiftreg_univ.sv
// Testbench for shiftreg_univ (WIDTH=8, CNT_W=4): directed operations with
// literal expectations plus a cycle-by-cycle arithmetic reference model.
module tb_shiftreg_univ;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       mode = 3'b000;
    logic [CNT_W-1:0] count = '0;
    logic [WIDTH-1:0] load_data = '0;
    logic             serial_in = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] dut_reg;
    logic             dut_so;
    logic             dut_busy;
    logic             dut_done;

    int checks = 0;
    int passes = 0;

    shiftreg_univ #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .mode       (mode),
        .count      (count),
        .load_data  (load_data),
        .serial_in  (serial_in),
        .abort      (abort),
        .register   (dut_reg),
        .serial_out (dut_so),
        .busy       (dut_busy),
        .done       (dut_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // One step expressed as plain 8-bit arithmetic.
    function automatic void step(input int r, input int md, input int si,
                                 output int nr, output int so);
        case (md)
            1: begin nr = (r * 2) % 256 + si;        so = r / 128; end
            2: begin nr = r / 2 + si * 128;          so = r % 2;   end
            3: begin nr = (r * 2) % 256 + r / 128;   so = r / 128; end
            4: begin nr = r / 2 + (r % 2) * 128;     so = r % 2;   end
            5: begin nr = r / 2 + (r / 128) * 128;   so = r % 2;   end
            default: begin nr = r; so = 0; end
        endcase
    endfunction

    // Reference model.
    int m_reg, m_so, m_left, m_mode;
    logic m_busy, m_done;
    int t_r, t_s;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg <= 0; m_so <= 0; m_left <= 0; m_mode <= 0;
            m_busy <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (abort) begin
                    m_busy <= 1'b0;
                    m_left <= 0;
                end else begin
                    step(m_reg, m_mode, int'(serial_in), t_r, t_s);
                    m_reg  <= t_r;
                    m_so   <= t_s;
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                    end
                end
            end else if (!m_done && start) begin
                if (mode == 3'd0) m_reg <= int'(load_data);
                else if (mode == 3'd6) m_reg <= 0;
                if (mode == 3'd0 || mode == 3'd6 || mode == 3'd7 || count == 0) begin
                    m_done <= 1'b1;
                end else begin
                    m_busy <= 1'b1;
                    m_left <= int'(count);
                    m_mode <= int'(mode);
                end
            end
        end
    end

    // Compare DUT against the model every cycle.
    always @(posedge clk) begin
        #1;
        chk("cyc_register", int'(dut_reg), m_reg);
        chk("cyc_serial_out", int'(dut_so), m_so);
        chk("cyc_busy", int'(dut_busy), int'(m_busy));
        chk("cyc_done", int'(dut_done), int'(m_done));
    end

    // Issue one operation (called at a negedge) and run it to its done pulse.
    // si==2 randomises serial_in each step; hold keeps start high while busy.
    task automatic do_op(input bit pre_wait, input int md, input int cnt, input int ld,
                         input int si, input bit hold, output int nbusy, output int ndone);
        if (pre_wait) @(negedge clk);
        mode      = 3'(md);
        count     = CNT_W'(cnt);
        load_data = WIDTH'(ld);
        serial_in = (si == 2) ? 1'($urandom) : 1'(si);
        start     = 1'b1;
        nbusy = 0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            mode      = 3'($urandom);
            count     = CNT_W'($urandom);
            load_data = WIDTH'($urandom);
            if (si == 2) serial_in = 1'($urandom);
            if (dut_busy) nbusy++;
            if (dut_done) begin
                ndone++;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        if (ndone == 0) chk("op_timeout", 0, 1);
    endtask

    int nb, nd;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_register", int'(dut_reg), 0);
        chk("rst_busy", int'(dut_busy), 0);
        chk("rst_done", int'(dut_done), 0);

        // Start accepted on the first edge after reset release.
        reset_n = 1'b1;
        do_op(1'b0, 0, 0, 'h5A, 0, 1'b0, nb, nd);
        chk("load_register", int'(dut_reg), 'h5A);
        chk("load_busy_cycles", nb, 0);
        chk("load_done_pulses", nd, 1);
        @(negedge clk);
        chk("load_done_one_cycle", int'(dut_done), 0);

        do_op(1'b1, 0, 0, 'h96, 0, 1'b0, nb, nd);
        do_op(1'b1, 1, 3, 0, 0, 1'b0, nb, nd);
        chk("shl_busy_cycles", nb, 3);
        chk("shl_register", int'(dut_reg), 'hB0);
        chk("shl_serial_out", int'(dut_so), 0);

        do_op(1'b1, 0, 0, 'h96, 0, 1'b0, nb, nd);
        do_op(1'b1, 5, 2, 0, 0, 1'b0, nb, nd);
        chk("asr_register", int'(dut_reg), 'hE5);
        chk("asr_serial_out", int'(dut_so), 1);

        do_op(1'b1, 0, 0, 'h81, 0, 1'b0, nb, nd);
        do_op(1'b1, 3, 9, 0, 0, 1'b0, nb, nd);
        chk("rol9_busy_cycles", nb, 9);
        chk("rol9_register", int'(dut_reg), 'h03);
        chk("rol9_serial_out", int'(dut_so), 1);

        // Abort a ROR-by-4 after two steps.
        do_op(1'b1, 0, 0, 'h01, 0, 1'b0, nb, nd);
        @(negedge clk);
        mode = 3'd4; count = CNT_W'(4); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_t0", int'(dut_busy), 1);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_register", int'(dut_reg), 'h40);
        chk("abort_serial_out", int'(dut_so), 0);
        chk("abort_busy", int'(dut_busy), 0);
        chk("abort_no_done", int'(dut_done), 0);
        mode = 3'd0; load_data = 8'h3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("after_abort_done", int'(dut_done), 1);
        chk("after_abort_register", int'(dut_reg), 'h3C);

        // Abort in IDLE is ignored; CLEAR keeps serial_out.
        abort = 1'b1;
        do_op(1'b1, 6, 5, 0, 0, 1'b0, nb, nd);
        abort = 1'b0;
        chk("clear_register", int'(dut_reg), 0);
        chk("clear_busy_cycles", nb, 0);
        chk("clear_serial_out", int'(dut_so), 0);

        do_op(1'b1, 0, 0, 'hC3, 0, 1'b0, nb, nd);
        do_op(1'b1, 7, 4, 'h11, 0, 1'b0, nb, nd);
        chk("rsvd_register", int'(dut_reg), 'hC3);
        chk("rsvd_busy_cycles", nb, 0);
        do_op(1'b1, 1, 0, 'h11, 1, 1'b0, nb, nd);
        chk("cnt0_register", int'(dut_reg), 'hC3);
        chk("cnt0_busy_cycles", nb, 0);

        // start held high through RUN is not queued.
        do_op(1'b1, 4, 3, 0, 0, 1'b1, nb, nd);
        chk("hold_busy_cycles", nb, 3);
        chk("hold_register", int'(dut_reg), 'h78);

        do_op(1'b1, 4, 8, 0, 0, 1'b0, nb, nd);
        chk("ror8_register", int'(dut_reg), 'h78);
        do_op(1'b1, 2, 15, 0, 2, 1'b0, nb, nd);
        chk("shr15_busy_cycles", nb, 15);
        do_op(1'b1, 1, 6, 0, 2, 1'b0, nb, nd);

        // Asynchronous reset in the middle of an SHR-by-8.
        do_op(1'b1, 0, 0, 'hFF, 0, 1'b0, nb, nd);
        @(negedge clk);
        mode = 3'd2; count = CNT_W'(8); serial_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_run_busy", int'(dut_busy), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_register", int'(dut_reg), 0);
        chk("async_rst_serial_out", int'(dut_so), 0);
        chk("async_rst_busy", int'(dut_busy), 0);
        chk("async_rst_done", int'(dut_done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (dut_done) nd++;
        end
        chk("post_rst_no_done", nd, 0);

        do_op(1'b0, 0, 0, 'hA5, 0, 1'b0, nb, nd);
        chk("final_load_register", int'(dut_reg), 'hA5);

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/shiftreg_univ.md
SHIFTREG_UNIV -- requirements
Module: shiftreg_univ

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, giving the register width in bits (WIDTH >= 2).
REQ-002 The block SHALL have a parameter CNT_W, default 4, giving the width of the shift-count input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: requests an operation; sampled only in IDLE.
REQ-006 The block SHALL have port mode, input, 3 bits: operation select, latched on accept.
REQ-007 The block SHALL have port count, input, CNT_W bits: number of shift steps, latched on accept.
REQ-008 The block SHALL have port load_data, input, WIDTH bits: parallel load value.
REQ-009 The block SHALL have port serial_in, input, 1 bit: fill bit for logical shifts, sampled every step.
REQ-010 The block SHALL have port abort, input, 1 bit: terminates a running operation.
REQ-011 The block SHALL have port register, output, WIDTH bits: current register contents.
REQ-012 The block SHALL have port serial_out, output, 1 bit: the bit that left the register on the most recent step (registered).
REQ-013 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 The mode encodings SHALL be:
- 000 LOAD
- 001 SHL (logical, fill serial_in)
- 010 SHR (logical, fill serial_in)
- 011 ROL
- 100 ROR
- 101 ASR (fill with MSB)
- 110 CLEAR
- 111 reserved (no-op)
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-017 In IDLE, start=1 at edge T0 SHALL latch mode and count.
REQ-018 If the latched mode is LOAD, CLEAR or reserved, or count==0, the block SHALL apply the operation at T0 (load_data, all-zero, or unchanged), go to DONE, and never assert busy.
REQ-019 Otherwise the block SHALL go to RUN at T0 and leave register unchanged at T0.
REQ-020 In RUN, each edge SHALL perform exactly one step and decrement the remaining count; the edge that performs step N SHALL transition to DONE.
REQ-021 Result: a count-N shift SHALL update register at edges T1..TN, busy SHALL be high during cycles T0+1..TN, and done SHALL be high for the one cycle after TN.
REQ-022 DONE SHALL return to IDLE after one cycle; start is ignored in RUN and DONE and SHALL NOT be queued.
REQ-023 For each step, serial_out SHALL take:
- MSB before the step for SHL and ROL;
- LSB before the step for SHR, ROR and ASR.
serial_out SHALL be unchanged by LOAD, CLEAR and reserved.
REQ-024 count SHALL be allowed to exceed WIDTH; every step SHALL be performed, with no modulo reduction (a rotate by WIDTH returns the original value).
REQ-025 abort=1 in RUN SHALL take priority over the step at that edge: no step is performed, the state goes to IDLE, register and serial_out keep their partial values, and no done pulse is issued.
REQ-026 abort in IDLE or DONE SHALL have no effect.
REQ-027 Inputs mode, count and load_data SHALL be ignored except at the accept edge; serial_in SHALL be sampled at each step edge.

Reset
REQ-028 reset_n=0 SHALL immediately, without waiting for clk, force: register=0, serial_out=0, busy=0, done=0, state=IDLE, latched count=0.
REQ-029 Reset asserted during RUN SHALL discard the operation; no done pulse SHALL follow reset release.
REQ-030 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Verification (WIDTH=8, CNT_W=4)
REQ-031 LOAD: start, mode=000, load_data=0x5A -> register=0x5A after T0; done high for 1 cycle; busy never high.
REQ-032 SHL: register=0x96, start, mode=001, count=3, serial_in=0 -> busy high 3 cycles; register=0xB0; serial_out=0; done pulse after T3.
REQ-033 ASR: register=0x96, mode=101, count=2 -> register=0xE5; serial_out=1.
REQ-034 ROL wrap: register=0x81, mode=011, count=9 -> busy high 9 cycles; register=0x03; serial_out=1.
REQ-035 Abort: register=0x01, mode=100, count=4, abort asserted at the edge after step 2 -> register=0x40; busy low next cycle; done never asserted; a start is accepted in the following cycle.
REQ-036 Reset mid-RUN: SHR count=8 in progress, pulse reset_n low asynchronously -> outputs immediately 0, state IDLE, no done after release.
